// File: rtl/input_debounce.sv
// input_debounce: conditions a raw asynchronous input into a clean debounced
// level plus single-cycle rise/fall pulses. A transition is accepted only
// after the sampled input has held its new value for STABLE_CYCLES clocks.
//
// Optional feature: define INPUT_DEBOUNCE_SYNC_EN to compile in the two-flop
// synchroniser (s1 -> s2). Without it, din is taken through a single flop and
// must already be synchronous to clk; all latencies shrink by one cycle.
//
// Ports:
//   clk      in   clock
//   rstn     in   synchronous active-low reset
//   din      in   raw input
//   level    out  debounced level
//   rise     out  one-cycle pulse on accepted 0->1
//   fall     out  one-cycle pulse on accepted 1->0
//   busy     out  high while a candidate transition is being qualified
//   evt_cnt  out  modulo-256 count of accepted rising transitions
module input_debounce #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       din,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] evt_cnt
);

  localparam int unsigned EVT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               busy_q, busy_d;
  logic [EVT_W-1:0]   evt_q, evt_d;
  logic               s1_q;
  logic               s;

  // Input sampling path
`ifdef INPUT_DEBOUNCE_SYNC_EN
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  assign s = s2_q;
`else
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q <= 1'b0;
    end else begin
      s1_q <= din;
    end
  end

  assign s = s1_q;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    evt_d   = evt_q;

    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_HI: begin
        if (!s) begin
          // glitch rejected, no pulse
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          evt_d   = evt_q + EVT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase

    // busy registered from the next state so it tracks state_q exactly
    busy_d = (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO);
  end

  assign level   = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = busy_q;
  assign evt_cnt = evt_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed self-checking bench for input_debounce with STABLE_CYCLES=4.
// Latency offsets adapt to whether INPUT_DEBOUNCE_SYNC_EN is defined.
module tb_input_debounce;

  localparam int SC = 4;
`ifdef INPUT_DEBOUNCE_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  // edge (counted from first sample of new din) at which level/pulse update
  localparam int ACC = SC + L;

  logic       clk;
  logic       rstn;
  logic       din;
  logic       level;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] evt_cnt;

  int n_tests;
  int n_fail;

  input_debounce #(
    .STABLE_CYCLES(SC),
    .CNT_W        (16)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .din    (din),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy),
    .evt_cnt(evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       din;
    logic       level;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] evt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic d, logic lv, logic ri, logic fa,
                              logic bz, logic [7:0] ev);
    vec_t v;
    v.rstn  = r;
    v.din   = d;
    v.level = lv;
    v.rise  = ri;
    v.fall  = fa;
    v.busy  = bz;
    v.evt   = ev;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // drive on falling edge, sample 1 ns after the rising edge
  task automatic step(input logic r, input logic d);
    @(negedge clk);
    rstn = r;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_rise;
    int rise_seen;
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    din     = 1'b0;

    // reset, then idle low for 20 cycles
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'd0));
    for (int i = 0; i < 20; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'd0));
    // accepted rise
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(1, 1, k >= ACC, k == ACC, 0, (k > L) && (k < ACC),
                       (k >= ACC) ? 8'd1 : 8'd0));
    // accepted fall
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(1, 0, k < ACC, 0, k == ACC, (k > L) && (k < ACC), 8'd1));
    // 3-cycle glitch: busy pulses, nothing else moves
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(1, k <= 3, 0, 0, 0, (k > L) && (k <= 3 + L), 8'd1));

    foreach (tbl[i]) begin
      step(tbl[i].rstn, tbl[i].din);
      check("level",   i, 8'(level),   8'(tbl[i].level));
      check("rise",    i, 8'(rise),    8'(tbl[i].rise));
      check("fall",    i, 8'(fall),    8'(tbl[i].fall));
      check("busy",    i, 8'(busy),    8'(tbl[i].busy));
      check("evt_cnt", i, evt_cnt,     tbl[i].evt);
      check("excl",    i, 8'(rise & fall), 8'd0);
    end

    // reset mid-qualification (WAIT_HI, cnt=2) with din held high
    for (int k = 1; k <= L + 2; k++) step(1, 1);
    check("midcnt_busy", 0, 8'(busy), 8'd1);
    step(0, 1);
    check("rst_level", 0, 8'(level), 8'd0);
    check("rst_rise",  0, 8'(rise),  8'd0);
    check("rst_fall",  0, 8'(fall),  8'd0);
    check("rst_busy",  0, 8'(busy),  8'd0);
    check("rst_evt",   0, evt_cnt,   8'd0);
    first_rise = 0;
    for (int k = 1; k <= ACC + 2; k++) begin
      step(1, 1);
      if (rise && first_rise == 0) first_rise = k;
    end
    check("rel_rise_edge", 0, 8'(first_rise), 8'(ACC));
    check("rel_level",     0, 8'(level),      8'd1);
    check("rel_evt",       0, evt_cnt,        8'd1);

    // evt_cnt wrap: 255 more rises, each preceded by an accepted fall
    rise_seen = 0;
    for (int n = 2; n <= 256; n++) begin
      for (int k = 1; k <= ACC; k++) step(1, 0);
      for (int k = 1; k <= ACC; k++) begin
        step(1, 1);
        if (rise) rise_seen++;
      end
      if (n == 255) check("evt_255", n, evt_cnt, 8'd255);
      if (n == 256) begin
        check("wrap_rise", n, 8'(rise), 8'd1);
        check("wrap_evt",  n, evt_cnt,  8'd0);
      end
    end
    check("wrap_rise_count", 0, 8'(rise_seen), 8'd255);
    step(1, 1);
    check("post_wrap_rise", 0, 8'(rise), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
# input_debounce

Conditions a raw asynchronous input (button, strap, external status pin) into a clean, glitch-free level plus single-cycle edge pulses. It sits directly upstream of the team's small control FSMs, which branch on a one-bit condition (`== 1` / `== 0`). Those FSMs consume `level` as that condition, or `rise`/`fall` when they need edge events. A transition is accepted only after the synchronised input has held its new value for `STABLE_CYCLES` consecutive clocks.

## Interface
- `STABLE_CYCLES`, default 1000: consecutive equal samples required to accept a transition; legal range 2 .. 2^`CNT_W`-1.
- `CNT_W`, default 16: width of the stability counter.
- `clk` input 1: clock.
- `rstn` input 1: reset, synchronous, active-low.
- `din` input 1: raw asynchronous input.
- `level` output 1: debounced level.
- `rise` output 1: one-cycle pulse when `level` goes 0->1.
- `fall` output 1: one-cycle pulse when `level` goes 1->0.
- `busy` output 1: high while a candidate transition is being qualified.
- `evt_cnt` output 8: count of accepted rising transitions; wraps.

## Operation
- Sample path: `din` -> `s1` -> `s2`, with `s = s2` (see Configuration).
- State machine has four states. Each line gives the current state and its transitions on the next clock edge:
  - LOW: `level`=0. If `s`=1, go to WAIT_HI with `cnt`<=1. Otherwise stay.
  - WAIT_HI: `level`=0, `busy`=1.
    - If `s`=0, go to LOW and clear `cnt`. This is a glitch reject: no pulse.
    - Else if `cnt`==`STABLE_CYCLES`-1, go to HIGH with `level`<=1, `rise`<=1, `evt_cnt`<=`evt_cnt`+1.
    - Else `cnt`<=`cnt`+1.
  - HIGH: `level`=1. If `s`=0, go to WAIT_LO with `cnt`<=1.
  - WAIT_LO: mirror of WAIT_HI with polarity swapped.
    - If `s`=1, go to HIGH and clear `cnt`.
    - On reaching the count, go to LOW with `level`<=0 and `fall`<=1.
- All outputs are registered. `busy` is decoded from registered state only.
- `rise` and `fall` are never both high. Each is high for exactly one cycle per accepted transition.
- `evt_cnt` is 8-bit modulo: 255 + 1 -> 0. It is not affected by `fall`.
- `cnt` never exceeds `STABLE_CYCLES`-1, so it never overflows `CNT_W`.
- Reset (`rstn`=0 at an edge), from any state including WAIT_* mid-count:
  - state becomes LOW.
  - `s1`, `s2`, `cnt`, `level`, `rise`, `fall`, `busy` and `evt_cnt` all go to 0.
  - If `din` is already high when reset is released, it is qualified as a normal rising transition.

## Timing
- Reset values: `level`=0, `rise`=0, `fall`=0, `busy`=0, `evt_cnt`=0.
- Edge numbering: edge 1 is the first rising edge at which `din` is sampled at its new value, and `din` then stays constant.
- With sync: `busy` rises at edge 3; `level`, and `rise` or `fall`, update at edge `STABLE_CYCLES`+2.
- Without sync: `busy` rises at edge 2; `level` and the pulse update at edge `STABLE_CYCLES`+1.
- Any opposite-value sample of `s` during WAIT_* returns the FSM to its stable state on the next edge. A later qualification restarts from `cnt`=1.
- Minimum accepted pulse width on `din`: `STABLE_CYCLES` clocks. Shorter pulses produce no output change.
- Back-to-back transitions: the earliest opposite transition can begin qualifying is the edge after the `rise`/`fall` edge.

## Configuration
- Macro: `INPUT_DEBOUNCE_SYNC_EN`.
- Defined: the two-flop synchroniser `s1` -> `s2` is compiled in, and `s = s2`. Use for truly asynchronous `din`.
- Undefined: `s2` is removed and `s = s1`. All latencies shrink by one cycle as listed in Timing. Use only when `din` is already synchronous to `clk`.

## Test plan
All scenarios use `STABLE_CYCLES`=4 with sync enabled.
- Reset, then `din` held 0 for 20 cycles -> `level`=0, `busy`=0, `rise`=0, `fall`=0, `evt_cnt`=0 throughout.
- `din` 0->1 at edge 1, then held -> `busy`=1 from edge 3; `level`=1 and a one-cycle `rise` at edge 6; `evt_cnt`=1.
- `din` high for 3 cycles, then low -> `busy` pulses, `level` stays 0, no `rise`, `evt_cnt` unchanged.
- From HIGH, `din` 1->0 held -> `level`=0 with a one-cycle `fall` at edge 6; `evt_cnt` unchanged.
- `rstn`=0 asserted while in WAIT_HI at `cnt`=2, with `din` held 1 -> all outputs 0 on the next edge. After release, `rise` follows the full 6-edge latency.
- 256 accepted rising transitions -> `evt_cnt` goes 255 -> 0 on the 256th `rise`.
